fetch_ctrl: RTL and testbench

//   Sequencer for the IF stage. Owns the PC and drives the synchronous inst_mem

---
 rtl/fetch_ctrl_pkg.sv | 19 +
 rtl/fetch_ctrl.sv | 113 +++++++++++
 tb/tb_fetch_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared widths, the downstream NOP encoding and the fetch sequencer state type.
// Every address increment in the IF stage goes through addr_inc so it wraps at 2^ADDR_W.
package fetch_ctrl_pkg;

  localparam int ADDR_W = 7;
  localparam int INST_W = 16;
  localparam logic [INST_W-1:0] NOP_INST = 16'h0000;

  typedef enum logic [1:0] {
    FC_BOOT = 2'd0,
    FC_RUN  = 2'd1,
    FC_HALT = 2'd2
  } fc_state_e;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: owns the PC, drives the synchronous inst_mem read port and
// resolves halt > branch > stall priority into IF/ID, ID/EX and EX/MEM stall/flush controls.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic              clk_n,
  input  logic              rst_n,
  input  logic              m_branch_en,
  input  logic [ADDR_W-1:0] m_branch_addr,
  input  logic              hz_stall,
  input  logic              wb_halt,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_data,
  output logic [INST_W-1:0] if_curr_inst,
  output logic [ADDR_W-1:0] if_next_addr,
  output logic              if_valid,
  output logic              stall_ifid,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              flush_exmem,
  output logic              halted
);

  fc_state_e         st, st_nxt;
  logic [ADDR_W-1:0] fetch_addr, fetch_addr_nxt;
  logic [ADDR_W-1:0] inst_pc, inst_pc_nxt;

  // rst_n is active-high and synchronous; it wins over every other input.
  always_ff @(posedge clk_n) begin
    if (rst_n) begin
      st         <= FC_BOOT;
      fetch_addr <= '0;
      inst_pc    <= '0;
    end else begin
      st         <= st_nxt;
      fetch_addr <= fetch_addr_nxt;
      inst_pc    <= inst_pc_nxt;
    end
  end

  // inst_pc always names the word currently on imem_data; a branch issues its target
  // to inst_mem in the same cycle so it appears on if_curr_inst one cycle later.
  always_comb begin
    st_nxt         = st;
    fetch_addr_nxt = fetch_addr;
    inst_pc_nxt    = inst_pc;
    imem_addr      = fetch_addr;
    if_valid       = 1'b0;
    if_curr_inst   = NOP_INST;
    stall_ifid     = 1'b0;
    flush_ifid     = 1'b0;
    flush_idex     = 1'b0;
    flush_exmem    = 1'b0;
    halted         = 1'b0;

    unique case (st)
      FC_BOOT: begin
        if (wb_halt) begin
          flush_ifid  = 1'b1;
          flush_idex  = 1'b1;
          flush_exmem = 1'b1;
          st_nxt      = FC_HALT;
        end else if (m_branch_en) begin
          flush_ifid     = 1'b1;
          flush_idex     = 1'b1;
          flush_exmem    = 1'b1;
          imem_addr      = m_branch_addr;
          inst_pc_nxt    = m_branch_addr;
          fetch_addr_nxt = addr_inc(m_branch_addr);
          st_nxt         = FC_RUN;
        end else begin
          inst_pc_nxt    = fetch_addr;
          fetch_addr_nxt = addr_inc(fetch_addr);
          st_nxt         = FC_RUN;
        end
      end

      FC_RUN: begin
        if_valid     = 1'b1;
        if_curr_inst = imem_data;
        if (wb_halt) begin
          flush_ifid  = 1'b1;
          flush_idex  = 1'b1;
          flush_exmem = 1'b1;
          st_nxt      = FC_HALT;
        end else if (m_branch_en) begin
          flush_ifid     = 1'b1;
          flush_idex     = 1'b1;
          flush_exmem    = 1'b1;
          imem_addr      = m_branch_addr;
          inst_pc_nxt    = m_branch_addr;
          fetch_addr_nxt = addr_inc(m_branch_addr);
        end else if (hz_stall) begin
          stall_ifid = 1'b1;
          imem_addr  = inst_pc;
        end else begin
          inst_pc_nxt    = fetch_addr;
          fetch_addr_nxt = addr_inc(fetch_addr);
        end
      end

      FC_HALT: begin
        halted    = 1'b1;
        imem_addr = inst_pc;
      end

      default: st_nxt = FC_BOOT;
    endcase
  end

  assign if_next_addr = addr_inc(inst_pc);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a 1-cycle synchronous ROM (mem[i] = 16'h1000 + i),
// directed scenarios, then randomized traffic checked against a PC-level reference model.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic              clk_n;
  logic              rst_n;
  logic              m_branch_en;
  logic [ADDR_W-1:0] m_branch_addr;
  logic              hz_stall;
  logic              wb_halt;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_data;
  logic [INST_W-1:0] if_curr_inst;
  logic [ADDR_W-1:0] if_next_addr;
  logic              if_valid;
  logic              stall_ifid;
  logic              flush_ifid;
  logic              flush_idex;
  logic              flush_exmem;
  logic              halted;

  logic [INST_W-1:0] rom [128];

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: fetch phase flags plus the PC of the word currently presented.
  bit m_booting;
  bit m_halted;
  int m_pc;

  fetch_ctrl dut (
    .clk_n        (clk_n),
    .rst_n        (rst_n),
    .m_branch_en  (m_branch_en),
    .m_branch_addr(m_branch_addr),
    .hz_stall     (hz_stall),
    .wb_halt      (wb_halt),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .if_curr_inst (if_curr_inst),
    .if_next_addr (if_next_addr),
    .if_valid     (if_valid),
    .stall_ifid   (stall_ifid),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .flush_exmem  (flush_exmem),
    .halted       (halted)
  );

  initial begin
    clk_n = 1'b0;
    forever #5 clk_n = ~clk_n;
  end

  always @(posedge clk_n) imem_data <= rom[imem_addr];

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_compare();
    bit br, hlt, hz;
    int exp_imem;
    br  = m_branch_en;
    hlt = wb_halt;
    hz  = hz_stall;
    check_output("next_addr", 32'(if_next_addr), 32'((m_pc + 1) % 128));
    if (m_halted) begin
      check_output("halted", 32'(halted), 32'd1);
      check_output("valid", 32'(if_valid), 32'd0);
      check_output("inst", 32'(if_curr_inst), 32'(NOP_INST));
      check_output("stall", 32'(stall_ifid), 32'd0);
      check_output("flush", 32'({flush_ifid, flush_idex, flush_exmem}), 32'd0);
      check_output("imem_addr", 32'(imem_addr), 32'(m_pc));
    end else if (m_booting) begin
      exp_imem = (br && !hlt) ? int'(m_branch_addr) : 0;
      check_output("halted", 32'(halted), 32'd0);
      check_output("valid", 32'(if_valid), 32'd0);
      check_output("inst", 32'(if_curr_inst), 32'(NOP_INST));
      check_output("stall", 32'(stall_ifid), 32'd0);
      check_output("flush", 32'({flush_ifid, flush_idex, flush_exmem}), (br || hlt) ? 32'd7 : 32'd0);
      check_output("imem_addr", 32'(imem_addr), 32'(exp_imem));
    end else begin
      check_output("halted", 32'(halted), 32'd0);
      if (!br && !hlt) begin
        check_output("valid", 32'(if_valid), 32'd1);
        check_output("inst", 32'(if_curr_inst), 32'(16'h1000 + m_pc));
      end
      check_output("stall", 32'(stall_ifid), (hz && !br && !hlt) ? 32'd1 : 32'd0);
      check_output("flush", 32'({flush_ifid, flush_idex, flush_exmem}), (br || hlt) ? 32'd7 : 32'd0);
      if (!hlt) begin
        exp_imem = br ? int'(m_branch_addr) : (hz ? m_pc : (m_pc + 1) % 128);
        check_output("imem_addr", 32'(imem_addr), 32'(exp_imem));
      end
    end
  endtask

  task automatic model_advance();
    if (rst_n) begin
      m_booting = 1'b1;
      m_halted  = 1'b0;
      m_pc      = 0;
    end else if (m_halted) begin
      m_halted = 1'b1;
    end else if (wb_halt) begin
      m_halted  = 1'b1;
      m_booting = 1'b0;
    end else if (m_branch_en) begin
      m_pc      = int'(m_branch_addr);
      m_booting = 1'b0;
    end else if (m_booting) begin
      m_booting = 1'b0;
      m_pc      = 0;
    end else if (!hz_stall) begin
      m_pc = (m_pc + 1) % 128;
    end
  endtask

  // One clock: drive inputs, compare at the falling edge, advance the model at the rising edge.
  task automatic apply_stimulus(input bit rst, input bit br, input int tgt, input bit hz, input bit hlt);
    rst_n         = rst;
    m_branch_en   = br;
    m_branch_addr = ADDR_W'(tgt);
    hz_stall      = hz;
    wb_halt       = hlt;
    @(negedge clk_n);
    model_compare();
    @(posedge clk_n);
    model_advance();
    #1;
  endtask

  initial begin
    bit r, b, z, h;
    for (int i = 0; i < 128; i++) rom[i] = 16'h1000 + 16'(i);
    rst_n = 1'b1; m_branch_en = 1'b0; m_branch_addr = '0; hz_stall = 1'b0; wb_halt = 1'b0;
    @(posedge clk_n);
    model_advance();
    #1;

    repeat (3) apply_stimulus(1, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("boot_inst0", 32'(if_curr_inst), 32'h1000);
    check_output("boot_next0", 32'(if_next_addr), 32'd1);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("boot_inst1", 32'(if_curr_inst), 32'h1001);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("boot_inst2", 32'(if_curr_inst), 32'h1002);

    repeat (3) apply_stimulus(0, 0, 0, 0, 0);
    check_output("pre_stall", 32'(if_curr_inst), 32'h1005);
    apply_stimulus(0, 0, 0, 1, 0);
    check_output("stall_hold1", 32'(if_curr_inst), 32'h1005);
    apply_stimulus(0, 0, 0, 1, 0);
    check_output("stall_hold2", 32'(if_curr_inst), 32'h1005);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("stall_release", 32'(if_curr_inst), 32'h1006);

    repeat (4) apply_stimulus(0, 0, 0, 0, 0);
    check_output("pre_branch", 32'(if_curr_inst), 32'h100A);
    apply_stimulus(0, 1, 40, 0, 0);
    check_output("branch_inst", 32'(if_curr_inst), 32'h1028);
    check_output("branch_next", 32'(if_next_addr), 32'd41);

    apply_stimulus(0, 1, 127, 1, 0);
    check_output("br_stall_inst", 32'(if_curr_inst), 32'h107F);
    check_output("br_stall_next", 32'(if_next_addr), 32'd0);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("wrap_inst", 32'(if_curr_inst), 32'h1000);

    apply_stimulus(0, 1, 20, 0, 1);
    check_output("halt_flag", 32'(halted), 32'd1);
    check_output("halt_valid", 32'(if_valid), 32'd0);
    repeat (5) apply_stimulus(0, $urandom_range(0, 1), $urandom_range(0, 127), $urandom_range(0, 1), 0);
    check_output("halt_sticky", 32'(halted), 32'd1);

    apply_stimulus(1, 0, 0, 0, 0);
    check_output("halt_reset", 32'(halted), 32'd0);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("refetch_halt", 32'(if_curr_inst), 32'h1000);
    apply_stimulus(0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1, 0);
    apply_stimulus(1, 0, 0, 1, 0);
    check_output("stall_reset_valid", 32'(if_valid), 32'd0);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("refetch_stall", 32'(if_curr_inst), 32'h1000);

    for (int n = 0; n < 2000; n++) begin
      r = m_halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 63) == 0);
      b = !m_booting && ($urandom_range(0, 7) == 0);
      h = !m_booting && ($urandom_range(0, 149) == 0);
      z = ($urandom_range(0, 3) == 0);
      apply_stimulus(r, b, $urandom_range(0, 127), z, h);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
